// File: rtl/uart_rx_frame.sv
// uart_rx_frame: 8E1 serial receiver (start, 8 data LSB first, even parity, stop).
// Define UART_RX_MAJORITY_EN for 2-of-3 majority sampling around every bit centre.
module uart_rx_frame #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int HALF_BIT     = CLKS_PER_BIT / 32'sd2
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       rx_line,
  output logic [7:0] data,
  output logic       rx_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
);

  localparam int CNT_W = (CLKS_PER_BIT > 32'sd2) ? $clog2(CLKS_PER_BIT) : 32'sd2;
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 32'sd1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  function automatic logic even_par(input logic [7:0] d);
    return ^d;
  endfunction

  state_t           state_r, state_nxt_s;
  logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
  logic [2:0]       bit_idx_r, bit_idx_nxt_s;
  logic [7:0]       shift_r, shift_nxt_s;
  logic             par_r, par_nxt_s;
  logic [7:0]       data_r, data_nxt_s;
  logic             valid_r, valid_nxt_s;
  logic             perr_r, perr_nxt_s;
  logic             ferr_r, ferr_nxt_s;
  logic             busy_r;
  logic             rx_meta_r, rx_sync_r, rx_prev_r;
  logic             tick_s, smp_s;

  // Two-flop synchronizer plus one delayed copy for falling-edge detection
  always_ff @(posedge clk) begin
    if (n_rst) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
      rx_prev_r <= 1'b1;
    end else begin
      rx_meta_r <= rx_line;
      rx_sync_r <= rx_meta_r;
      rx_prev_r <= rx_sync_r;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  localparam logic [CNT_W-1:0] HALF_TICK = CNT_W'(HALF_BIT);

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  logic [1:0] hist_r;
  logic       pend_r;

  // Keeps samples T-1 and T; pend_r marks the cycle after T (counter already wrapped)
  always_ff @(posedge clk) begin
    if (n_rst) begin
      hist_r <= 2'b11;
      pend_r <= 1'b0;
    end else begin
      hist_r <= {hist_r[0], rx_sync_r};
      pend_r <= (state_r inside {ST_DATA, ST_PARITY, ST_STOP}) && (cnt_r == LAST_CNT);
    end
  end

  assign smp_s  = maj3(hist_r[1], hist_r[0], rx_sync_r);
  assign tick_s = (state_r == ST_START) ? (cnt_r == HALF_TICK) : pend_r;
`else
  localparam logic [CNT_W-1:0] HALF_TICK = CNT_W'(HALF_BIT - 32'sd1);

  assign smp_s  = rx_sync_r;
  assign tick_s = (state_r == ST_START) ? (cnt_r == HALF_TICK) : (cnt_r == LAST_CNT);
`endif

  // Next-state, sampling and result computation
  always_comb begin
    state_nxt_s   = state_r;
    cnt_nxt_s     = cnt_r;
    bit_idx_nxt_s = bit_idx_r;
    shift_nxt_s   = shift_r;
    par_nxt_s     = par_r;
    data_nxt_s    = data_r;
    valid_nxt_s   = 1'b0;
    perr_nxt_s    = perr_r;
    ferr_nxt_s    = ferr_r;

    case (state_r)
      ST_IDLE: begin
        bit_idx_nxt_s = 3'd0;
        // A line still low after a bad stop bit has no edge, so it cannot retrigger
        if (rx_prev_r && !rx_sync_r) begin
          state_nxt_s = ST_START;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (tick_s) begin
          if (!smp_s) begin
            state_nxt_s = ST_DATA;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end else begin
          state_nxt_s = ST_START;
        end
      end
      ST_DATA: begin
        if (tick_s) begin
          shift_nxt_s[bit_idx_r] = smp_s;
          bit_idx_nxt_s          = bit_idx_r + 3'd1;
          if (bit_idx_r == 3'd7) begin
            state_nxt_s = ST_PARITY;
          end else begin
            state_nxt_s = ST_DATA;
          end
        end else begin
          state_nxt_s = ST_DATA;
        end
      end
      ST_PARITY: begin
        if (tick_s) begin
          par_nxt_s   = smp_s;
          state_nxt_s = ST_STOP;
        end else begin
          state_nxt_s = ST_PARITY;
        end
      end
      ST_STOP: begin
        if (tick_s) begin
          data_nxt_s  = shift_r;
          perr_nxt_s  = (even_par(shift_r) != par_r);
          ferr_nxt_s  = ~smp_s;
          valid_nxt_s = 1'b1;
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_STOP;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase

    // Counter restarts on frame entry/exit and at DATA entry, otherwise free-runs per bit
    if (state_r == ST_IDLE || state_nxt_s == ST_IDLE ||
        (state_r == ST_START && state_nxt_s != ST_START)) begin
      cnt_nxt_s = CNT_ZERO;
    end else if (cnt_r == LAST_CNT) begin
      cnt_nxt_s = CNT_ZERO;
    end else begin
      cnt_nxt_s = cnt_r + CNT_ONE;
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (n_rst) begin
      state_r   <= ST_IDLE;
      cnt_r     <= CNT_ZERO;
      bit_idx_r <= 3'd0;
      shift_r   <= 8'd0;
      par_r     <= 1'b0;
      data_r    <= 8'd0;
      valid_r   <= 1'b0;
      perr_r    <= 1'b0;
      ferr_r    <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      cnt_r     <= cnt_nxt_s;
      bit_idx_r <= bit_idx_nxt_s;
      shift_r   <= shift_nxt_s;
      par_r     <= par_nxt_s;
      data_r    <= data_nxt_s;
      valid_r   <= valid_nxt_s;
      perr_r    <= perr_nxt_s;
      ferr_r    <= ferr_nxt_s;
      busy_r    <= (state_nxt_s != ST_IDLE);
    end
  end

  assign data       = data_r;
  assign rx_valid   = valid_r;
  assign parity_err = perr_r;
  assign frame_err  = ferr_r;
  assign busy       = busy_r;

endmodule

// File: tb/tb_uart_rx_frame.sv
// tb_uart_rx_frame: randomized self-checking bench for uart_rx_frame against a
// frame-level reference model (expected byte/flags queued per transmitted frame).
module tb_uart_rx_frame;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       rx_line;
  logic [7:0] data;
  logic       rx_valid;
  logic       parity_err;
  logic       frame_err;
  logic       busy;

  uart_rx_frame #(.CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .rx_line    (rx_line),
    .data       (data),
    .rx_valid   (rx_valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       fe;
    int         t0;
  } frame_t;

  frame_t     exp_q[$];
  frame_t     mon_f;
  int         n_checks = 0;
  int         n_pass   = 0;
  int         cyc      = 0;
  logic [7:0] last_d   = 8'd0;
  logic       last_pe  = 1'b0;
  logic       last_fe  = 1'b0;
  logic       prev_valid = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic drive_bit(input logic v);
    rx_line = v;
    repeat (CPB) @(negedge clk);
  endtask

  // Model: receiver reports the byte, parity mismatch and stop==0 of every complete frame
  task automatic send_frame(input logic [7:0] b, input logic par, input logic stp,
                            input int gap_bits);
    frame_t f;
    f.d  = b;
    f.pe = ((^b) != par);
    f.fe = ~stp;
    f.t0 = cyc;
    exp_q.push_back(f);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(par);
    drive_bit(stp);
    repeat (gap_bits) drive_bit(1'b1);
  endtask

  // Output monitor sampling on the falling edge
  initial begin
    forever begin
      @(negedge clk);
      if (!n_rst && rx_valid) begin
        check("single_cycle_strobe", int'(prev_valid), 0);
        if (exp_q.size() == 0) begin
          check("unexpected_strobe", 1, 0);
        end else begin
          mon_f = exp_q.pop_front();
          check("data", int'(data), int'(mon_f.d));
          check("parity_err", int'(parity_err), int'(mon_f.pe));
          check("frame_err", int'(frame_err), int'(mon_f.fe));
          check("busy_at_strobe", int'(busy), 0);
          check("latency_in_window",
                int'((cyc - mon_f.t0) >= 169 && (cyc - mon_f.t0) <= 174), 1);
          last_d  = mon_f.d;
          last_pe = mon_f.pe;
          last_fe = mon_f.fe;
        end
      end
      prev_valid = rx_valid;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] b;
    logic       par;
    logic       stp;
    int         gap;
    logic [7:0] abort_byte;

    rx_line = 1'b1;
    n_rst   = 1'b1;
    repeat (3) @(negedge clk);
    n_rst = 1'b0;
    check("rst_data", int'(data), 0);
    check("rst_valid", int'(rx_valid), 0);
    check("rst_perr", int'(parity_err), 0);
    check("rst_ferr", int'(frame_err), 0);
    check("rst_busy", int'(busy), 0);
    repeat (CPB) @(negedge clk);

    send_frame(8'hA5, 1'b0, 1'b1, 2);
    send_frame(8'h3C, 1'b1, 1'b1, 2);

    // Bad stop, then line held low three bit times: exactly one strobe
    send_frame(8'h81, 1'b0, 1'b0, 0);
    repeat (3) drive_bit(1'b0);
    drive_bit(1'b1);
    check("low_hold_no_busy", int'(busy), 0);
    send_frame(8'h12, 1'b0, 1'b1, 2);

    // Short glitch on idle line is rejected at the start-bit centre
    rx_line = 1'b0;
    repeat (4) @(negedge clk);
    rx_line = 1'b1;
    repeat (2) @(negedge clk);
    check("glitch_busy_start", int'(busy), 1);
    repeat (3 * CPB) @(negedge clk);
    check("glitch_busy_idle", int'(busy), 0);
    check("glitch_data_held", int'(data), int'(last_d));
    check("glitch_perr_held", int'(parity_err), int'(last_pe));
    check("glitch_ferr_held", int'(frame_err), int'(last_fe));

    // Back-to-back frames with no idle gap
    send_frame(8'h00, 1'b0, 1'b1, 0);
    send_frame(8'hFF, 1'b0, 1'b1, 0);
    send_frame(8'h55, 1'b0, 1'b1, 3);

    // Reset during data bit 4 abandons the frame
    abort_byte = 8'hC3;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(abort_byte[i]);
    rx_line = abort_byte[4];
    repeat (CPB / 2) @(negedge clk);
    check("abort_busy_before", int'(busy), 1);
    n_rst = 1'b1;
    @(negedge clk);
    n_rst = 1'b0;
    check("abort_data", int'(data), 0);
    check("abort_valid", int'(rx_valid), 0);
    check("abort_perr", int'(parity_err), 0);
    check("abort_ferr", int'(frame_err), 0);
    check("abort_busy", int'(busy), 0);
    last_d  = 8'd0;
    last_pe = 1'b0;
    last_fe = 1'b0;
    rx_line = 1'b1;
    repeat (12 * CPB) @(negedge clk);
    send_frame(8'h5A, 1'b0, 1'b1, 2);

`ifdef UART_RX_MAJORITY_EN
    // One-cycle inverted spike at the centre of data bit 2 of 0x0F
    begin
      frame_t f;
      f.d  = 8'h0F;
      f.pe = 1'b0;
      f.fe = 1'b0;
      f.t0 = cyc;
      exp_q.push_back(f);
      drive_bit(1'b0);
      drive_bit(1'b1);
      drive_bit(1'b1);
      rx_line = 1'b1;
      repeat (9) @(negedge clk);
      rx_line = 1'b0;
      @(negedge clk);
      rx_line = 1'b1;
      repeat (CPB - 10) @(negedge clk);
      drive_bit(1'b1);
      for (int i = 4; i < 8; i++) drive_bit(1'b0);
      drive_bit(1'b0);
      drive_bit(1'b1);
      repeat (2) drive_bit(1'b1);
    end
`endif

    // Randomized frames with occasional parity and stop faults
    for (int n = 0; n < 20; n++) begin
      b   = 8'($urandom_range(0, 255));
      par = ^b;
      if ($urandom_range(0, 3) == 0) par = ~par;
      stp = ($urandom_range(0, 5) != 0);
      gap = $urandom_range(0, 2);
      if (!stp && gap == 0) gap = 1;
      send_frame(b, par, stp, gap);
    end

    repeat (4 * CPB) @(negedge clk);
    check("pending_frames", exp_q.size(), 0);
    check("final_busy", int'(busy), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_frame.md
Name: uart_rx_frame

Overview:
- Serial receiver that sits directly downstream of the UART transmitter and consumes its tx_line.
- Frame format: start bit (0), 8 data bits LSB first, even-parity bit (XOR of the data bits), stop bit (1).
- Default timing is 9600 baud from a 50 MHz clock.
- Delivers the received byte with a one-cycle valid strobe and per-frame parity and framing error flags.

Parameters:
CLKS_PER_BIT, 5208, clock cycles per bit period (50 MHz / 9600)
HALF_BIT, CLKS_PER_BIT/2, cycles from start-edge detection to the start-bit mid-point check

Ports:
clk  input  1  system clock; all logic is on the rising edge
n_rst  input  1  reset; synchronous and active-high (asserted = 1, despite the name)
rx_line  input  1  asynchronous serial input; idles high
data  output  8  last received byte; held until the next frame completes
rx_valid  output  1  one-cycle pulse when data and the error flags update
parity_err  output  1  1 = received parity bit differs from ^data; valid with rx_valid and held until the next update
frame_err  output  1  1 = stop bit sampled 0; valid with rx_valid and held until the next update
busy  output  1  1 = FSM is in any state other than IDLE

Behaviour:
- Input synchronizer:
  - rx_line passes through a 2-FF synchronizer, giving rx_s.
  - A third flop holds rx_d (previous rx_s).
  - Both synchronizer flops and rx_d reset to 1.
- Reset (n_rst = 1 at a clock edge):
  - data = 0, rx_valid = 0, parity_err = 0, frame_err = 0, busy = 0.
  - FSM goes to IDLE; baud counter and bit index clear.
  - Reset mid-frame abandons the frame; no rx_valid is produced for it.
- Baud counter: counts 0..CLKS_PER_BIT-1, clears on every state entry. Bit index: 0..7.
- FSM states and transitions:
  - IDLE:
    - Waits for a falling edge (rx_d = 1, rx_s = 0); then go to START.
    - Edge detection, not level detection: a line held low does not retrigger.
  - START:
    - When the counter reaches HALF_BIT-1, sample rx_s.
    - Sample 0: go to DATA, counter cleared.
    - Sample 1: glitch; go to IDLE with no flags and no strobe.
  - DATA:
    - When the counter reaches CLKS_PER_BIT-1, sample rx_s into shift[bit index] (LSB first) and increment the bit index.
    - After bit 7, go to PARITY.
  - PARITY: at CLKS_PER_BIT-1, latch the parity sample; go to STOP.
  - STOP: at CLKS_PER_BIT-1, sample the stop bit. In that same cycle:
    - data <= shift.
    - parity_err <= (^shift) != parity sample.
    - frame_err <= ~stop sample.
    - Assert rx_valid for the next cycle only.
    - Go to IDLE.
- Back-to-back frames:
  - Returning to IDLE at mid-stop-bit guarantees a start edge arriving one half-bit later is caught.
  - No idle gap between frames is required.
- Frame with frame_err = 1:
  - Still strobed and data is still delivered.
  - IDLE then waits for rx_s to return to 1 before the next falling edge can arm.
- Latency: rx_valid asserts 2 (sync) + HALF_BIT + 10·CLKS_PER_BIT + 1 cycles after the start-bit falling edge on rx_line, ±1 cycle for sync phase.
- The flags and data of a previous frame are not cleared at the start of a new frame; they change only on rx_valid.

Optional Feature:
- Macro: UART_RX_MAJORITY_EN.
- Defined:
  - Every sample point (start check, data, parity, stop) takes rx_s at counter values T-1, T and T+1, where T is the nominal sample count.
  - The sampled bit is the 2-of-3 majority.
  - Decisions and state transitions occur at T+1, so the whole frame timing is delayed by one cycle.
  - Sample T+1 for the non-start states is taken with the counter wrapping to 0 for the next bit; the counter must therefore free-run across bit boundaries within a frame.
- Undefined: single sample at T exactly as described in Behaviour.

Test Plan:
- Reset, then send 0xA5 with correct parity bit 0 and stop 1, CLKS_PER_BIT = 16 -> one rx_valid pulse; data = 0xA5, parity_err = 0, frame_err = 0, busy low after the strobe.
- Send 0x3C with parity bit forced to 1 -> data = 0x3C, parity_err = 1, frame_err = 0.
- Send 0x81 with stop bit driven 0 and the line then held low 3 bit times -> rx_valid once, data = 0x81, frame_err = 1; no second strobe until the line goes high then low again.
- 4-cycle low glitch on an idle line -> START rejects it, FSM back in IDLE, no rx_valid, flags unchanged from the previous frame.
- Frames 0x00, 0xFF, 0x55 back-to-back with zero idle between them -> three strobes with the correct bytes, parity_err = 0 each.
- Assert n_rst during DATA bit 4 of a frame -> all outputs 0 on the next cycle, no strobe; a following clean 0x5A frame is received correctly.
- With UART_RX_MAJORITY_EN: a one-cycle inverted spike at the mid-point of data bit 2 of 0x0F -> data = 0x0F.
